// File: rtl/reg16_change_capture_fifo.sv
// reg16_change_capture_fifo: queues every new value of a monitored register into a small FWFT FIFO
// drained over a valid/ready stream, with fill level and a sticky overflow flag.
module reg16_change_capture_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [WIDTH-1:0]      Q_in,
    input  logic                  enable,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clear_overflow
);
    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0]    prev_q;
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push_req;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;

    assign push_req  = enable && (Q_in != prev_q);
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop       = !empty && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign level     = wr_ptr - rd_ptr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            prev_q <= Q_in;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= Q_in;
    end
endmodule
